burst_xfer_sequencer: RTL
=========================

Name: burst_xfer_sequencer

Overview:
Controller that turns one kernel transfer command (start address, total beats) into a sequence of burst requests for the memory-mover datapath. It caps the number of in-flight bursts with an internal up/down outstanding counter. It splits the transfer at C_MAX_BURST and at 4 KiB address boundaries. It pulses done once every issued burst has completed, and sits between the kernel control logic and the AXI read/write master.

Parameters:
C_ADDR_WIDTH, 64, byte address width
C_LEN_WIDTH, 32, width of total-beat count in a command
C_BEAT_BYTES, 64, bytes per data beat; power of 2, 1..4096
C_MAX_BURST, 64, max beats per burst; power of 2, C_MAX_BURST*C_BEAT_BYTES <= 4096
C_MAX_OUTSTANDING, 16, max bursts issued but not yet completed; >= 1

Ports:
clk  in  1  single clock, all logic on posedge
rst  in  1  synchronous active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when valid & ready
cmd_addr  in  C_ADDR_WIDTH  start byte address, C_BEAT_BYTES aligned
cmd_len  in  C_LEN_WIDTH  total beats; 0 is legal
req_valid  out  1  burst request valid
req_ready  in  1  datapath accepts request
req_addr  out  C_ADDR_WIDTH  burst start byte address
req_len  out  $clog2(C_MAX_BURST)+1  burst length in beats, 1..C_MAX_BURST
burst_done  in  1  one-cycle pulse per completed burst
outstanding  out  $clog2(C_MAX_OUTSTANDING)+1  bursts in flight
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse at transfer completion

Behaviour:
- The clock port is clk; the reset port is rst. There is one clock, and reset is synchronous and active-high.
- States are IDLE, ISSUE, DRAIN and DONE.
- Reset values: state IDLE, cmd_ready 1, req_valid 0, req_addr 0, req_len 0, outstanding 0, busy 0, done 0. All outputs are registered.
- IDLE: cmd_ready = 1.
  - On cmd handshake, latch addr and remaining = cmd_len.
  - cmd_len != 0: go to ISSUE; req_valid may assert in the next cycle at the earliest (1-cycle latency).
  - cmd_len == 0: go to DONE.
- ISSUE:
  - Burst size = min(remaining, C_MAX_BURST, (4096 - addr[11:0]) / C_BEAT_BYTES).
  - Assert req_valid only while outstanding < C_MAX_OUTSTANDING.
  - Once req_valid is high, req_valid, req_addr and req_len stay stable until req_ready.
  - On handshake: addr += req_len*C_BEAT_BYTES and remaining -= req_len.
  - If remaining reaches 0, go to DRAIN. Otherwise the next request may be valid in the following cycle.
  - Full rate is permitted: back-to-back requests one per cycle while req_ready stays high.
- Outstanding counter:
  - +1 on req handshake; -1 on burst_done.
  - Both in the same cycle: value unchanged.
  - burst_done with outstanding == 0 is ignored; the counter never wraps below 0 or above C_MAX_OUTSTANDING.
  - burst_done is honoured in every state except reset.
- DRAIN: req_valid = 0. When registered outstanding == 0, go to DONE.
- DONE: done = 1 for exactly one cycle, then go to IDLE. cmd_ready returns the cycle after done.
- busy = (state != IDLE). cmd_ready = 0 outside IDLE.
- Address arithmetic wraps modulo 2^C_ADDR_WIDTH. No burst crosses a 4 KiB boundary.
- rst asserted in any state, including mid-handshake: the next cycle shows the reset values, and in-flight state (addr, remaining, outstanding) is discarded.
- No error output. Misaligned cmd_addr is undefined behaviour; an assertion flags it in simulation.

Test Plan:
All scenarios use C_BEAT_BYTES=64 and C_MAX_BURST=64.
1. addr 0x0, len 128, req_ready=1 -> requests (0x0000,64) and (0x1000,64) on consecutive cycles. outstanding goes 1 then 2. Two burst_done pulses -> DRAIN exits; done pulses 1 cycle later; busy falls with it.
2. addr 0xF80, len 10 -> requests (0xF80,2) then (0x1000,8), split at the 4 KiB boundary.
3. len 0 -> no req_valid at all; done pulses 2 cycles after the cmd handshake; cmd_ready=1 the following cycle.
4. C_MAX_OUTSTANDING=2, len 256, no burst_done -> exactly 2 handshakes, then req_valid=0 with outstanding=2. One burst_done -> req_valid re-asserts with addr 0x2000, len 64.
5. outstanding=1, req handshake and burst_done in the same cycle -> outstanding stays 1. burst_done at outstanding=0 -> stays 0.
6. req_ready held 0 for 5 cycles -> req_addr and req_len stable throughout. rst in ISSUE -> next cycle req_valid=0, outstanding=0, cmd_ready=1, done=0.

Source files
------------

// File: rtl/burst_xfer_sequencer.sv
// rtl/burst_xfer_sequencer.sv - splits one transfer command into 4 KiB-safe burst requests with an in-flight cap
module burst_xfer_sequencer #(
  parameter int C_ADDR_WIDTH      = 64,
  parameter int C_LEN_WIDTH       = 32,
  parameter int C_BEAT_BYTES      = 64,
  parameter int C_MAX_BURST       = 64,
  parameter int C_MAX_OUTSTANDING = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 cmd_valid,
  output logic                                 cmd_ready,
  input  logic [C_ADDR_WIDTH-1:0]              cmd_addr,
  input  logic [C_LEN_WIDTH-1:0]               cmd_len,
  output logic                                 req_valid,
  input  logic                                 req_ready,
  output logic [C_ADDR_WIDTH-1:0]              req_addr,
  output logic [$clog2(C_MAX_BURST):0]         req_len,
  input  logic                                 burst_done,
  output logic [$clog2(C_MAX_OUTSTANDING):0]   outstanding,
  output logic                                 busy,
  output logic                                 done
);

  localparam int AW       = C_ADDR_WIDTH;
  localparam int LW       = C_LEN_WIDTH;
  localparam int RLW      = $clog2(C_MAX_BURST) + 1;
  localparam int OW       = $clog2(C_MAX_OUTSTANDING) + 1;
  localparam int BB_SHIFT = $clog2(C_BEAT_BYTES);
  localparam int CW       = (LW > 14) ? LW : 14;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t          state;
  logic [AW-1:0]   addr;
  logic [LW-1:0]   remaining;

  logic            req_hs;
  logic            done_ok;
  logic [OW-1:0]   out_next;
  logic [AW-1:0]   addr_next;
  logic [LW-1:0]   rem_next;
  logic [12:0]     room;
  logic [CW-1:0]   cap;
  logic [CW-1:0]   rem_w;
  logic [CW-1:0]   burst_len;
  logic            can_issue;

  assign req_hs  = req_valid & req_ready;
  // A completion reported with nothing in flight is dropped so the counter cannot underflow.
  assign done_ok = burst_done & (outstanding != '0);

  always_comb begin
    out_next = outstanding;
    if (req_hs && !done_ok)
      out_next = outstanding + OW'(1);
    else if (!req_hs && done_ok)
      out_next = outstanding - OW'(1);
  end

  // Next request is sized from the post-handshake address so requests can issue every cycle.
  assign addr_next = req_hs ? addr + (AW'(req_len) << BB_SHIFT) : addr;
  assign rem_next  = req_hs ? remaining - LW'(req_len) : remaining;
  assign room      = (13'd4096 - {1'b0, addr_next[11:0]}) >> BB_SHIFT;
  assign cap       = (CW'(room) < CW'(C_MAX_BURST)) ? CW'(room) : CW'(C_MAX_BURST);
  assign rem_w     = CW'(rem_next);
  assign burst_len = (rem_w < cap) ? rem_w : cap;
  assign can_issue = out_next < OW'(C_MAX_OUTSTANDING);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cmd_ready   <= 1'b1;
      req_valid   <= 1'b0;
      req_addr    <= '0;
      req_len     <= '0;
      outstanding <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      addr        <= '0;
      remaining   <= '0;
    end else begin
      outstanding <= out_next;
      done        <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            addr      <= cmd_addr;
            remaining <= cmd_len;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= (cmd_len != '0) ? S_ISSUE : S_DONE;
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        S_ISSUE: begin
          addr      <= addr_next;
          remaining <= rem_next;
          // A stalled request holds its payload; nothing else may move it.
          if (!(req_valid && !req_ready)) begin
            if (rem_next == '0) begin
              req_valid <= 1'b0;
              state     <= S_DRAIN;
            end else begin
              req_valid <= can_issue;
              req_addr  <= addr_next;
              req_len   <= RLW'(burst_len);
            end
          end
        end
        S_DRAIN: begin
          if (outstanding == '0)
            state <= S_DONE;
        end
        S_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  a_cmd_addr_aligned: assert property (@(posedge clk) disable iff (rst)
    (cmd_valid && cmd_ready) |-> ((cmd_addr & AW'(C_BEAT_BYTES - 1)) == '0));

endmodule
